// File: rtl/dff_pkg.sv
// Shared defaults and data typedef for the dff_core register slice.
package dff_pkg;

  localparam int unsigned DefaultWidth = 1;

  typedef logic [DefaultWidth-1:0] data_t;

  localparam data_t DefaultResetVal = '0;

endpackage

// File: rtl/dff_if.sv
// Bundle of the dff_core signals for connecting a register to its driver.
interface dff_if #(
  parameter int unsigned WIDTH = dff_pkg::DefaultWidth
) (
  input logic clk
);

  logic             rst_n;
  logic             en;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;

  modport dut (
    input  clk,
    input  rst_n,
    input  en,
    input  d,
    output q,
    output qbar
  );

  modport tb (
    input  clk,
    output rst_n,
    output en,
    output d,
    input  q,
    input  qbar
  );

endinterface

// File: rtl/dff_bit.sv
// Single-bit flop with async active-low reset, load enable and registered complement.
module dff_bit #(
  parameter bit ResetVal = 1'b0,
  parameter bit HasEn    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic d_i,
  output logic q_o,
  output logic qbar_o
);

  logic load;
  logic q_d, q_q;
  logic qbar_d, qbar_q;

  assign load = en_i | ~HasEn;

  // qbar has its own flop so it never glitches while q settles.
  always_comb begin
    q_d    = q_q;
    qbar_d = qbar_q;
    if (load) begin
      q_d    = d_i;
      qbar_d = ~d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= ResetVal;
      qbar_q <= ~ResetVal;
    end else begin
      q_q    <= q_d;
      qbar_q <= qbar_d;
    end
  end

  assign q_o    = q_q;
  assign qbar_o = qbar_q;

endmodule

// File: rtl/dff_core.sv
// Parameterised register with true and complementary outputs, built from dff_bit slices.
module dff_core
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH     = DefaultWidth,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               HAS_EN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] qbar_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_bit #(
      .ResetVal (RESET_VAL[i]),
      .HasEn    (HAS_EN)
    ) u_bit (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (en_i),
      .d_i    (d_i[i]),
      .q_o    (q_o[i]),
      .qbar_o (qbar_o[i])
    );
  end

  a_qbar_complement: assert property (@(posedge clk) disable iff (!rst_n) qbar_o == ~q_o);

  a_reset_value: assert property (@(posedge clk)
    !rst_n |-> (q_o == RESET_VAL) && (qbar_o == ~RESET_VAL));

  // An unknown enable makes the load decision meaningless.
  a_en_known: assert property (@(posedge clk) disable iff (!rst_n)
    HAS_EN |-> !$isunknown(en_i));

endmodule

// File: tb/tb_dff_core.sv
// Directed bench for dff_core: 1-bit, 8-bit non-zero reset, and enable-less variants.
module tb_dff_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       d1, q1, qb1;
  logic       dn, qn, qbn;
  logic [7:0] d8, q8, qb8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dff_core u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en),
    .d_i    (d1),
    .q_o    (q1),
    .qbar_o (qb1)
  );

  dff_core #(
    .WIDTH     (8),
    .RESET_VAL (8'hA5)
  ) u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en),
    .d_i    (d8),
    .q_o    (q8),
    .qbar_o (qb8)
  );

  dff_core #(
    .HAS_EN (1'b0)
  ) u_dutn (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en),
    .d_i    (dn),
    .q_o    (qn),
    .qbar_o (qbn)
  );

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b1;
    d1    = 1'b1;
    dn    = 1'b1;
    d8    = 8'hFF;
    #1 rst_n = 1'b0;

    // Reset held across clock edges with d = 1
    step();
    check_eq("rst_q1", {7'b0, q1}, 8'h00);
    check_eq("rst_qb1", {7'b0, qb1}, 8'h01);
    check_eq("rst_q8", q8, 8'hA5);
    check_eq("rst_qb8", qb8, 8'h5A);
    check_eq("rst_qn", {7'b0, qn}, 8'h00);
    step();
    check_eq("rst_q1_hold", {7'b0, q1}, 8'h00);
    check_eq("rst_q8_hold", q8, 8'hA5);

    rst_n = 1'b1;
    d1 = 1'b0; dn = 1'b0; d8 = 8'hA5;
    step();
    check_eq("rel_q1", {7'b0, q1}, 8'h00);
    check_eq("rel_qb1", {7'b0, qb1}, 8'h01);

    // Basic load sequence
    d1 = 1'b1; dn = 1'b1;
    step();
    check_eq("ld1_q1", {7'b0, q1}, 8'h01);
    check_eq("ld1_qb1", {7'b0, qb1}, 8'h00);
    check_eq("ld1_qn", {7'b0, qn}, 8'h01);
    d1 = 1'b0; dn = 1'b0;
    step();
    check_eq("ld0_q1", {7'b0, q1}, 8'h00);
    check_eq("ld0_qb1", {7'b0, qb1}, 8'h01);
    d1 = 1'b1; dn = 1'b1;
    step();
    check_eq("ld1b_q1", {7'b0, q1}, 8'h01);

    // Enable hold; the enable-less flop keeps loading
    en = 1'b0; d1 = 1'b0; dn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("hold_q1", {7'b0, q1}, 8'h01);
      check_eq("hold_qb1", {7'b0, qb1}, 8'h00);
      check_eq("noen_qn", {7'b0, qn}, 8'h00);
      check_eq("noen_qbn", {7'b0, qbn}, 8'h01);
    end
    en = 1'b1;
    step();
    check_eq("reen_q1", {7'b0, q1}, 8'h00);
    check_eq("reen_qb1", {7'b0, qb1}, 8'h01);

    // Wide load and hold
    d8 = 8'h3C;
    step();
    check_eq("w_q8", q8, 8'h3C);
    check_eq("w_qb8", qb8, 8'hC3);
    en = 1'b0; d8 = 8'hFF;
    step();
    check_eq("w_hold_q8", q8, 8'h3C);
    check_eq("w_hold_qb8", qb8, 8'hC3);
    en = 1'b1;

    // d changes just after the edge: q keeps the old value until the next edge
    d1 = 1'b1;
    step();
    check_eq("setup_pre", {7'b0, q1}, 8'h01);
    d1 = 1'b0;
    #2;
    check_eq("setup_old", {7'b0, q1}, 8'h01);
    check_eq("setup_oldb", {7'b0, qb1}, 8'h00);
    step();
    check_eq("setup_new", {7'b0, q1}, 8'h00);

    // Asynchronous reset between edges
    d1 = 1'b1; d8 = 8'h0F;
    step();
    check_eq("async_pre_q1", {7'b0, q1}, 8'h01);
    check_eq("async_pre_q8", q8, 8'h0F);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_q1", {7'b0, q1}, 8'h00);
    check_eq("async_qb1", {7'b0, qb1}, 8'h01);
    check_eq("async_q8", q8, 8'hA5);
    check_eq("async_qb8", qb8, 8'h5A);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("post_q1", {7'b0, q1}, 8'h01);
    check_eq("post_q8", q8, 8'h0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
